// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler: FSM state encoding and
// the phase-counter sizing function.
package pulse_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_PULSE = 3'd2,
    ST_LEAVE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward with
// wrap-around and reports the first set bit as one-hot and as an index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             any
);

  assign any = |req;

  always_comb begin
    int j;
    logic found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      j = (int'(ptr) + off) % N_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Round-robin shared pulse sequencer: grants one requester, then runs the
// warn / pulse / leave phases followed by an enforced idle gap.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int PRE_CYCLES   = 2,
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             about_to_pulse,
  output logic             comb_pulse,
  output logic             leaving,
  output logic             done,
  output logic             busy
);

  localparam int PW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max3(PRE_CYCLES, PULSE_CYCLES, GAP_CYCLES) + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [PW-1:0]      winner_reg, winner_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic               about_reg, pulse_reg, leave_reg, done_reg, busy_reg;

  logic [N_REQ-1:0]   arb_onehot;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Phase counter is loaded with the phase length on entry and leaves at 1.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    winner_next = winner_reg;
    gnt_next    = gnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          winner_next = arb_idx;
          gnt_next    = arb_onehot;
          state_next  = ST_ARM;
          cnt_next    = CNT_W'(PRE_CYCLES);
        end
      end
      ST_ARM: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_PULSE;
          cnt_next   = CNT_W'(PULSE_CYCLES);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_LEAVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_LEAVE: begin
        ptr_next = (winner_reg == PW'(N_REQ - 1)) ? '0 : winner_reg + PW'(1);
        gnt_next = '0;
        if (GAP_CYCLES > 0) begin
          state_next = ST_GAP;
          cnt_next   = CNT_W'(GAP_CYCLES);
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        gnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they stay Moore-clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      winner_reg <= '0;
      gnt_reg    <= '0;
      about_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
      leave_reg  <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ptr_reg    <= ptr_next;
      winner_reg <= winner_next;
      gnt_reg    <= gnt_next;
      about_reg  <= (state_next == ST_ARM);
      pulse_reg  <= (state_next == ST_PULSE);
      leave_reg  <= (state_next == ST_LEAVE);
      done_reg   <= (state_next == ST_LEAVE);
      busy_reg   <= (state_next != ST_IDLE);
    end
  end

  assign gnt            = gnt_reg;
  assign about_to_pulse = about_reg;
  assign comb_pulse     = pulse_reg;
  assign leaving        = leave_reg;
  assign done           = done_reg;
  assign busy           = busy_reg;

endmodule

// File: tb/tb_pulse_sched.sv
// Bench for pulse_sched: two builds (GAP=2 and GAP=0) driven by the same
// stimulus and compared every cycle against a timeline-based reference model.
module tb_pulse_sched;

  localparam int PRE   = 2;
  localparam int PULSE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt0, gnt1;
  logic       atp0, cp0, lv0, dn0, bz0;
  logic       atp1, cp1, lv1, dn1, bz1;

  always #5 clk = ~clk;

  pulse_sched #(.N_REQ(4), .PRE_CYCLES(PRE), .PULSE_CYCLES(PULSE), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .about_to_pulse(atp0),
    .comb_pulse(cp0), .leaving(lv0), .done(dn0), .busy(bz0)
  );

  pulse_sched #(.N_REQ(4), .PRE_CYCLES(PRE), .PULSE_CYCLES(PULSE), .GAP_CYCLES(0)) u_dut_nogap (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .about_to_pulse(atp1),
    .comb_pulse(cp1), .leaving(lv1), .done(dn1), .busy(bz1)
  );

  wire [8:0] obs0 = {gnt0, atp0, cp0, lv0, dn0, bz0};
  wire [8:0] obs1 = {gnt1, atp1, cp1, lv1, dn1, bz1};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int s_m[2];
  int ptr_m[2];
  int win_m[2];
  int gap_m[2] = '{2, 0};
  logic [8:0] e0, e1;

  // Expected outputs k cycles after the granting edge, from phase lengths.
  function automatic logic [8:0] model_out(input int k, input int w, input int g);
    logic [3:0] one;
    logic [3:0] gv;
    logic a, p, l, b;
    one = 4'b0001;
    gv  = (k >= 1 && k <= PRE + PULSE + 1) ? (one << w) : 4'b0000;
    a   = (k >= 1 && k <= PRE);
    p   = (k > PRE && k <= PRE + PULSE);
    l   = (k == PRE + PULSE + 1);
    b   = (k >= 1 && k <= PRE + PULSE + 1 + g);
    return {gv, a, p, l, l, b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s_m[i]   = -1000;
      ptr_m[i] = 0;
      win_m[i] = 0;
    end
  endtask

  // Drive req for one edge, advance the model, sample 1 time unit later.
  task automatic step(input logic [3:0] r, output logic [8:0] x0, output logic [8:0] x1);
    req = r;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if ((cyc - s_m[i]) >= PRE + PULSE + 2 + gap_m[i] && r != 4'b0000) begin
        for (int off = 0; off < 4; off++) begin
          int j;
          j = (ptr_m[i] + off) % 4;
          if (r[j]) begin
            win_m[i] = j;
            break;
          end
        end
        s_m[i]   = cyc;
        ptr_m[i] = (win_m[i] + 1) % 4;
      end
    end
    #1;
    x0 = model_out(cyc - s_m[0] + 1, win_m[0], gap_m[0]);
    x1 = model_out(cyc - s_m[1] + 1, win_m[1], gap_m[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    cyc++;
    #1;
    n_checks++;
    if ({obs0, obs1} !== 18'd0) $display("FAIL reset_state dut0=%b dut1=%b required 0", obs0, obs1);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    step(4'b0000, e0, e1);
    n_checks++;
    if ({obs0, obs1} !== {e0, e1}) $display("FAIL reset_idle dut0=%b dut1=%b exp0=%b exp1=%b", obs0, obs1, e0, e1);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      step((c == 0) ? 4'b0100 : 4'b0000, e0, e1);
      n_checks++;
      if ({obs0, obs1} !== {e0, e1}) $display("FAIL single c%0d dut0=%b dut1=%b exp0=%b exp1=%b", c, obs0, obs1, e0, e1);
      else n_pass++;
      if (c == 5) begin
        n_checks++;
        if ({gnt0, lv0, dn0} !== 6'b010011) $display("FAIL single_leave gnt=%b lv=%b dn=%b required 0100/1/1", gnt0, lv0, dn0);
        else n_pass++;
      end
    end
    do_reset();
    step(4'b1100, e0, e1);
    n_checks++;
    if (gnt0 !== 4'b0100) $display("FAIL single_pair gnt=%b required 0100", gnt0);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] order[$];
    logic [3:0] prev;
    logic [3:0] want[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    prev = 4'b0000;
    for (int c = 0; c < 46; c++) begin
      step(4'b1111, e0, e1);
      n_checks++;
      if ({obs0, obs1} !== {e0, e1}) $display("FAIL rr c%0d dut0=%b dut1=%b exp0=%b exp1=%b", c, obs0, obs1, e0, e1);
      else n_pass++;
      if (prev == 4'b0000 && gnt0 != 4'b0000) order.push_back(gnt0);
      prev = gnt0;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= order.size()) $display("FAIL rr_order idx%0d missing grant required %b", i, want[i]);
      else if (order[i] !== want[i]) $display("FAIL rr_order idx%0d got %b required %b", i, order[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pat[3] = '{4'b0010, 4'b0011, 4'b0011};
    logic [3:0] want[3] = '{4'b0010, 4'b0001, 4'b0010};
    do_reset();
    for (int t = 0; t < 3; t++) begin
      step(pat[t], e0, e1);
      n_checks++;
      if (gnt0 !== want[t] || gnt1 !== want[t]) $display("FAIL wrap t%0d gnt0=%b gnt1=%b required %b", t, gnt0, gnt1, want[t]);
      else n_pass++;
      for (int c = 0; c < 10; c++) begin
        step(4'b0000, e0, e1);
        n_checks++;
        if ({obs0, obs1} !== {e0, e1}) $display("FAIL wrap_seq t%0d c%0d dut0=%b exp0=%b", t, c, obs0, e0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_drop();
    int dones;
    do_reset();
    dones = 0;
    for (int c = 0; c < 11; c++) begin
      step((c < 2) ? 4'b0010 : 4'b0000, e0, e1);
      n_checks++;
      if ({obs0, obs1} !== {e0, e1}) $display("FAIL drop c%0d dut0=%b dut1=%b exp0=%b exp1=%b", c, obs0, obs1, e0, e1);
      else n_pass++;
      if (dn0) dones++;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL drop_done count=%0d required 1", dones);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int dones;
    do_reset();
    step(4'b0010, e0, e1);
    for (int c = 0; c < 3; c++) step(4'b0000, e0, e1);
    n_checks++;
    if (cp0 !== 1'b1) $display("FAIL areset_pre pulse=%b required 1", cp0);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({obs0, obs1} !== 18'd0) $display("FAIL areset_now dut0=%b dut1=%b required 0", obs0, obs1);
    else n_pass++;
    @(posedge clk);
    cyc++;
    #1;
    n_checks++;
    if ({obs0, obs1} !== 18'd0) $display("FAIL areset_hold dut0=%b dut1=%b required 0", obs0, obs1);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      step((c == 0) ? 4'b1000 : 4'b0000, e0, e1);
      n_checks++;
      if ({obs0, obs1} !== {e0, e1}) $display("FAIL areset_seq c%0d dut0=%b exp0=%b", c, obs0, e0);
      else n_pass++;
      if (c == 0) begin
        n_checks++;
        if (gnt0 !== 4'b1000) $display("FAIL areset_gnt gnt=%b required 1000", gnt0);
        else n_pass++;
      end
      if (dn0) dones++;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL areset_done count=%0d required 1", dones);
    else n_pass++;
  endtask

  task automatic test_gap0();
    int leave_c;
    int regrant_c;
    do_reset();
    leave_c   = -1;
    regrant_c = -1;
    for (int c = 0; c < 20; c++) begin
      step(4'b0001, e0, e1);
      n_checks++;
      if ({obs0, obs1} !== {e0, e1}) $display("FAIL gap0 c%0d dut1=%b exp1=%b", c, obs1, e1);
      else n_pass++;
      if (lv1 && leave_c < 0) leave_c = c;
      else if (leave_c >= 0 && regrant_c < 0 && gnt1 == 4'b0001) regrant_c = c;
    end
    n_checks++;
    if (leave_c != 5 || regrant_c != 7) $display("FAIL gap0_timing leave=%0d regrant=%0d required 5/7", leave_c, regrant_c);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, e0, e1);
      n_checks++;
      if ({obs0, obs1} !== {e0, e1}) $display("FAIL random c%0d req=%b dut0=%b dut1=%b exp0=%b exp1=%b", c, r, obs0, obs1, e0, e1);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_drop();
    test_async_reset();
    test_gap0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
